// File: rtl/crc16_pkg.sv
// Shared CRC-16 definitions (poly x^16+x^15+x^2+1) and frame FSM state type.
// The trailer's final XOR is selected in the top by CRC16_APPENDER_FINAL_XOR_EN.
package crc16_pkg;

   localparam logic [15:0] CRC16_POLY         = 16'h8005;
   localparam logic [15:0] CRC16_INIT_DEFAULT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BODY  = 2'd1,
      TRAIL = 2'd2
   } state_e;

   // 32-bit parallel update, MSB-first: d[31] enters the register first.
   function automatic logic [15:0] crc16_d32_next(input logic [15:0] crc,
                                                  input logic [31:0] d);
      logic [15:0] c;
      c = crc;
      for (int i = 31; i >= 0; i--) begin
         if (c[15] ^ d[i]) begin
            c = {c[14:0], 1'b0} ^ CRC16_POLY;
         end else begin
            c = {c[14:0], 1'b0};
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/crc16_out_reg.sv
// Single-entry registered valid/ready output stage carrying data, sop, eop and crc flag.
// Handshake: a beat moves when valid & ready; held stable while valid & ~ready.
module crc16_out_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid_i,
   input  logic [31:0] in_data_i,
   input  logic        in_sop_i,
   input  logic        in_eop_i,
   input  logic        in_crc_i,
   output logic        in_ready_o,
   output logic        out_valid_o,
   output logic [31:0] out_data_o,
   output logic        out_sop_o,
   output logic        out_eop_o,
   output logic        out_crc_o,
   input  logic        out_ready_i
);

   logic        valid_q;
   logic [31:0] data_q;
   logic        sop_q;
   logic        eop_q;
   logic        crc_q;

   // The register can take a new beat when empty or when its current beat leaves.
   assign in_ready_o = ~valid_q | out_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= 32'h0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         crc_q   <= 1'b0;
      end else if (in_ready_o) begin
         valid_q <= in_valid_i;
         sop_q   <= in_valid_i & in_sop_i;
         eop_q   <= in_valid_i & in_eop_i;
         crc_q   <= in_valid_i & in_crc_i;
         if (in_valid_i) begin
            data_q <= in_data_i;
         end
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;
   assign out_sop_o   = sop_q;
   assign out_eop_o   = eop_q;
   assign out_crc_o   = crc_q;

endmodule

// File: rtl/crc16_frame_appender.sv
// Computes CRC-16 over each frame's 32-bit words and appends one trailer word carrying it.
// Define CRC16_APPENDER_FINAL_XOR_EN to invert the CRC placed in the trailer.
module crc16_frame_appender
   import crc16_pkg::*;
#(
   parameter logic [15:0] CRC_INIT = CRC16_INIT_DEFAULT,
   parameter int          LEN_W    = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      s_data,
   input  logic             s_valid,
   input  logic             s_sop,
   input  logic             s_eop,
   output logic             s_ready,
   output logic [31:0]      m_data,
   output logic             m_valid,
   output logic             m_sop,
   output logic             m_eop,
   output logic             m_crc,
   input  logic             m_ready,
   output logic [LEN_W-1:0] frame_len,
   output logic             frame_done,
   output logic             err_sop,
   output logic [1:0]       dbg_state
);

   localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

   state_e           state_q;
   logic [15:0]      crc_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] frame_len_q;
   logic             frame_done_q;
   logic             err_sop_q;

   logic             or_ready;
   logic             accept;
   logic             trail_load;
   logic             trail_xfer;
   logic [15:0]      crc_final;
   logic [15:0]      crc_restart;
   logic [15:0]      crc_cont;

   logic             fwd_valid;
   logic [31:0]      fwd_data;
   logic             fwd_sop;
   logic             fwd_eop;
   logic             fwd_crc;

`ifdef CRC16_APPENDER_FINAL_XOR_EN
   assign crc_final = crc_q ^ 16'hFFFF;
`else
   assign crc_final = crc_q;
`endif

   assign s_ready     = or_ready & (state_q != TRAIL);
   assign accept      = s_valid & s_ready;
   assign trail_load  = (state_q == TRAIL) & or_ready;
   assign trail_xfer  = m_valid & m_ready & m_crc;
   assign crc_restart = crc16_d32_next(CRC_INIT, s_data);
   assign crc_cont    = crc16_d32_next(crc_q, s_data);

   // Trailer takes priority; otherwise forward accepted beats that belong to a frame.
   always_comb begin
      fwd_valid = 1'b0;
      fwd_data  = s_data;
      fwd_sop   = 1'b0;
      fwd_eop   = 1'b0;
      fwd_crc   = 1'b0;
      if (state_q == TRAIL) begin
         fwd_valid = 1'b1;
         fwd_data  = {16'h0000, crc_final};
         fwd_eop   = 1'b1;
         fwd_crc   = 1'b1;
      end else if (accept && (s_sop || (state_q == BODY))) begin
         fwd_valid = 1'b1;
         fwd_sop   = s_sop;
      end
   end

   // TRAIL lasts until the trailer enters the output register, so the next
   // sop can be accepted while the trailer transfers (N+1 cycles per frame).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         crc_q        <= CRC_INIT;
         len_q        <= '0;
         frame_len_q  <= '0;
         frame_done_q <= 1'b0;
         err_sop_q    <= 1'b0;
      end else begin
         frame_done_q <= trail_xfer;
         err_sop_q    <= 1'b0;
         if (trail_xfer) begin
            frame_len_q <= len_q;
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (s_sop) begin
                     crc_q   <= crc_restart;
                     len_q   <= LEN_W'(1);
                     state_q <= s_eop ? TRAIL : BODY;
                  end else begin
                     err_sop_q <= 1'b1;
                  end
               end
            end
            BODY: begin
               if (accept) begin
                  if (s_sop) begin
                     err_sop_q <= 1'b1;
                     crc_q     <= crc_restart;
                     len_q     <= LEN_W'(1);
                     state_q   <= s_eop ? TRAIL : BODY;
                  end else begin
                     crc_q <= crc_cont;
                     if (len_q != LEN_MAX) begin
                        len_q <= len_q + LEN_W'(1);
                     end
                     if (s_eop) begin
                        state_q <= TRAIL;
                     end
                  end
               end
            end
            TRAIL: begin
               if (trail_load) begin
                  crc_q   <= CRC_INIT;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   crc16_out_reg u_out_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (fwd_valid),
      .in_data_i   (fwd_data),
      .in_sop_i    (fwd_sop),
      .in_eop_i    (fwd_eop),
      .in_crc_i    (fwd_crc),
      .in_ready_o  (or_ready),
      .out_valid_o (m_valid),
      .out_data_o  (m_data),
      .out_sop_o   (m_sop),
      .out_eop_o   (m_eop),
      .out_crc_o   (m_crc),
      .out_ready_i (m_ready)
   );

   assign frame_len  = frame_len_q;
   assign frame_done = frame_done_q;
   assign err_sop    = err_sop_q;
   assign dbg_state  = state_q;

endmodule
